// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: drives the combinational boot ROM, buffers {pc, word} pairs in a
// small prefetch FIFO and hands them to decode over valid/ready. Optional counters: IFETCH_PERF_EN.
module ifetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
`ifdef IFETCH_PERF_EN
    output logic [31:0] instr_pc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`else
    output logic [31:0] instr_pc
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          push, pop;

    // Push looks only at registered count, so ready never reaches rom_addr combinationally.
    assign push        = (count < FULL) && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr_valid = (count != '0);
    assign instr_data  = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign rom_addr    = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= rom_data;
        end
    end

`ifdef IFETCH_PERF_EN
    // Free-running; a redirect does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (instr_valid && !instr_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch against a small boot-ROM image; define IFETCH_PERF_EN
// to also check the performance counters.
module tb_ifetch_prefetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_addr, rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0000_1117;
            32'h0000_0004: rom = 32'h8e01_0113;
            32'h0000_0034: rom = 32'h0000_f7b7;
            default:       rom = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign rom_data = rom(rom_addr);

    ifetch_prefetch dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data),
`ifdef IFETCH_PERF_EN
        .instr_pc(instr_pc),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`else
        .instr_pc(instr_pc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_data"}, instr_data, rom(pc));
    endtask

    initial begin
        rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        #2;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_data", instr_data, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_romaddr", rom_addr, 32'd0);
        @(negedge clk);

        // 1: stream with ready=1, one instruction per cycle
        rst_n = 1'b1;
        step();
        chk("t1_data0", instr_data, 32'h0000_1117);
        chk_head("t1_h0", 32'h0);
        step();
        chk("t1_data4", instr_data, 32'h8e01_0113);
        chk_head("t1_h4", 32'h4);
        step();
        chk_head("t1_h8", 32'h8);

        // 2: backpressure fills the FIFO, then drain in order
        rst_n = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(8);
        chk_head("t2_hold", 32'h0);
        chk("t2_romaddr", rom_addr, 32'h10);
        instr_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk_head("t2_drain", 32'(4 * i));
        end

        // 3: redirect with FIFO full
        instr_ready = 1'b0;
        step(5);
        chk("t3_full_romaddr", rom_addr, 32'h28);
        redirect_valid = 1'b1; redirect_pc = 32'h34;
        step();
        chk("t3_bubble", {31'd0, instr_valid}, 32'd0);
        chk("t3_romaddr", rom_addr, 32'h34);
        redirect_valid = 1'b0; instr_ready = 1'b1;
        step();
        chk("t3_data34", instr_data, 32'h0000_f7b7);
        chk_head("t3_h34", 32'h34);
        step();
        chk_head("t3_h38", 32'h38);

        // 4: misaligned redirect while head is being accepted
        redirect_valid = 1'b1; redirect_pc = 32'h36;
        step();
        chk("t4_bubble", {31'd0, instr_valid}, 32'd0);
        chk("t4_romaddr", rom_addr, 32'h34);
        redirect_valid = 1'b0;
        step();
        chk_head("t4_h34", 32'h34);

        // back-to-back redirects: last one wins
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_pc = 32'h200;
        step();
        chk("b2b_valid", {31'd0, instr_valid}, 32'd0);
        chk("b2b_romaddr", rom_addr, 32'h200);
        redirect_valid = 1'b0;
        step();
        chk_head("b2b_h200", 32'h200);

        // PC wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk_head("wrap_top", 32'hFFFF_FFFC);
        step();
        chk_head("wrap_zero", 32'h0);

        // 5: asynchronous reset mid-stream
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_romaddr", rom_addr, 32'h0);
        chk("t5_pc", instr_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_head("t5_h0", 32'h0);
        step();
        chk_head("t5_h4", 32'h4);

`ifdef IFETCH_PERF_EN
        // 6: counters from a clean reset: 10 pushes at ready=1, 3 more filling, 3 stalls
        rst_n = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("t6_rst_fetch", perf_fetch_cnt, 32'd0);
        rst_n = 1'b1;
        step(10);
        instr_ready = 1'b0;
        step(3);
        chk("t6_stall", perf_stall_cnt, 32'd3);
        chk("t6_fetch", perf_fetch_cnt, 32'd13);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("t6_redir_keep", perf_fetch_cnt, 32'd13);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
